sync_fifo_param: RTL
====================

Name: sync_fifo_param

Overview:
- Parametrised synchronous single-clock FIFO; next generation of the team's 32x8 FIFO.
- Generalised width and depth, supporting DEPTH values up to 2^16.
- Supports true simultaneous read+write in one cycle.
- Provides an exact occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags.
- Sits between producer/consumer datapath stages in the embedded pipeline.

Parameters:
- DATA_W, 32, data word width in bits (>=1).
- DEPTH, 8, number of entries; power of two, >=2.
- AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH.

Ports:
- Clk  in  1  clock, all logic on rising edge.
- Rst  in  1  synchronous reset, active-high.
- en  in  1  global enable; 0 freezes all state except reset.
- wr_en  in  1  write request.
- din  in  DATA_W  write data.
- rd_en  in  1  read request.
- dout  out  DATA_W  read data.
- rd_valid  out  1  dout updated this cycle.
- count  out  AW+1  occupancy 0..DEPTH, where AW = clog2(DEPTH).
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- almost_empty  out  1  count<=AE_THRESH.
- almost_full  out  1  count>=AF_THRESH.
- ovf  out  1  sticky overflow.
- udf  out  1  sticky underflow.

Behaviour:
- Reset:
  - Rst is sampled at a Clk edge and overrides en.
  - wptr=rptr=0, count=0, dout=0, rd_valid=0, ovf=udf=0.
  - Storage contents are not cleared.
  - Rst asserted mid-operation discards all queued data in that cycle; any simultaneous rd/wr is ignored.
- Pointers:
  - wptr and rptr are AW bits wide and wrap naturally from DEPTH-1 to 0; no compare-and-clear.
  - count is a separate AW+1-bit register. It is never derived from pointer difference.
- Flags: empty, full, almost_* are combinational decodes of registered count.
- Accept rules, evaluated only when en=1:
  - wr_acc = wr_en & (!full | rd_acc)
  - rd_acc = rd_en & !empty
- Write: on wr_acc, mem[wptr]<=din and wptr<=wptr+1.
- Read:
  - On rd_acc, dout<=mem[rptr], rptr<=rptr+1, and rd_valid<=1 in the next cycle.
  - Read latency is 1 cycle from the rd_en edge.
  - If no rd_acc, rd_valid<=0 and dout holds its last value.
- Count update:
  - count+1 on wr_acc only.
  - count-1 on rd_acc only.
  - Unchanged when both or neither accept.
- Simultaneous read and write:
  - Full with rd_en and wr_en: both accepted; count stays DEPTH. The read returns the oldest word, and the write takes the freed slot.
  - Empty with rd_en and wr_en: write only, count becomes 1, udf is set, rd_valid=0.
- Errors:
  - ovf<=1 when en & wr_en & !wr_acc.
  - udf<=1 when en & rd_en & empty.
  - Both flags clear only on Rst.
- en=0: no pointer, count, dout or flag change; rd_valid<=0.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - dout continuously presents mem[rptr] combinationally.
  - rd_valid = !empty.
  - rd_en acts as acknowledge: it pops the head, and the next word appears in the same cycle after the edge.
  - Read latency is 0.
  - Accept rules, count and error flags are unchanged.
- Undefined: registered 1-cycle-latency read as described above.

Decomposition:
- Package fifo_pkg:
  - clog2 constant function.
  - Localparam AW.
  - Typedef for the count width.
- One sub-module, fifo_mem: simple dual-port RAM, DATA_W x DEPTH, with synchronous write and either a registered read port or, under FWFT, an asynchronous read port.
- Control, count and flags stay in sync_fifo_param.

Test Plan (DATA_W=32, DEPTH=8, AF=6, AE=2):
- Rst=1 for 2 cycles with en=1 -> count=0, empty=1, full=0, almost_empty=1, dout=0, ovf=udf=0.
- Write 0xA0..0xA7 over 8 cycles, then a 9th write of 0xFF -> full=1, count=8, almost_full from count=6, ovf=1; reading 8 words returns 0xA0..0xA7, never 0xFF.
- Full FIFO, rd_en=wr_en=1 with din=0xB0 for 3 cycles -> count stays 8, dout=0xA0,0xA1,0xA2; later reads end with 0xB0,0xB0,0xB0.
- Empty FIFO, rd_en=1 alone -> rd_valid=0, udf=1, count=0; then rd_en=wr_en=1 with din=0xC3 -> count=1, next read returns 0xC3.
- 20 writes interleaved with 20 reads (pointer wrap twice) -> data returned in order, count never exceeds 8.
- en=0 with wr_en=rd_en=1 -> no state change; Rst=1 with en=0 at count=5 -> count=0, empty=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers and types for the parametrised synchronous FIFO.
// Provides a constant clog2, the default-configuration address/count widths
// and the accept-decision struct used by the FIFO control logic.
package fifo_pkg;

  // Ceiling log2 for sizing pointers; clog2(1) = 0, clog2(8) = 3, clog2(65536) = 16.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // Default configuration (8 entries). Instances with other depths derive
  // their own widths from clog2(DEPTH).
  localparam int DEFAULT_DEPTH = 8;
  localparam int AW            = clog2(DEFAULT_DEPTH);

  // Occupancy for the default configuration: 0..DEPTH needs one bit more than a pointer.
  typedef logic [AW:0] count_t;

  // Per-cycle accept decisions for the write and read sides.
  typedef struct packed {
    logic wr;
    logic rd;
  } acc_t;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port RAM, DATA_W x DEPTH, synchronous write.
// Default build: registered read port (1-cycle latency, output clears on Rst).
// With SYNC_FIFO_FWFT_EN defined: asynchronous read port (head word visible
// combinationally), used for first-word-fall-through operation.
module fifo_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_rd_en,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  // NOTE: storage has no reset; clearing it would force flops instead of RAM
  // and nothing reads a slot before it has been written.
  logic [DATA_W-1:0] r_mem [DEPTH];

  // Store the incoming word at the write address on an accepted write.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (i_wr_en) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN

  // Head word is presented continuously; Rst and read strobe are not needed.
  logic w_unused;
  assign w_unused = ^{Rst, i_rd_en};
  assign o_rdata  = r_mem[i_raddr];

`else

  logic [DATA_W-1:0] r_rdata;

  // Registered read: capture the addressed word on an accepted read, else hold.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_rdata <= '0;
    end else if (i_rd_en) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

`endif

endmodule : fifo_mem

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with exact occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Optional macro SYNC_FIFO_FWFT_EN selects first-word-fall-through reads
// (zero latency, rd_valid = !empty); default is a registered 1-cycle read.
// Reset (Rst) is synchronous, active-high, and overrides the global enable.
module sync_fifo_param #(
  parameter int  DATA_W    = 32,
  parameter int  DEPTH     = 8,
  parameter int  AF_THRESH = DEPTH - 2,
  parameter int  AE_THRESH = 2,
  localparam int AW        = fifo_pkg::clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              en,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              rd_valid,
  output logic [AW:0]       count,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic              ovf,
  output logic              udf
);

  import fifo_pkg::*;

  // Thresholds and depth sized to the count register for clean compares.
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_THRESH);

  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;
  logic              r_ovf;
  logic              r_udf;
  logic              w_empty;
  logic              w_full;
  logic [DATA_W-1:0] w_rdata;
  acc_t              w_acc;

  // Status decodes come straight from the registered count, never from pointers.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_C);

  // Accept decisions: a read needs data; a write needs room or a same-cycle read
  // freeing a slot. Nothing is accepted while disabled or in reset.
  always_comb begin
    // NOTE: defaults first so every path assigns w_acc and no latch is inferred.
    w_acc = '0;
    if (!Rst && en) begin
      w_acc.rd = rd_en & ~w_empty;
      w_acc.wr = wr_en & (~w_full | w_acc.rd);
    end
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else if (en) begin
      // Pointers are exactly AW bits and wrap from DEPTH-1 to 0 by overflow.
      if (w_acc.wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_acc.rd) begin
        r_rptr <= r_rptr + 1'b1;
      end

      // Count moves only when exactly one side is accepted.
      case ({w_acc.wr, w_acc.rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // A refused write is an overflow; a read request on empty is an underflow,
      // even when a simultaneous write is accepted.
      if (wr_en && !w_acc.wr) begin
        r_ovf <= 1'b1;
      end
      if (rd_en && w_empty) begin
        r_udf <= 1'b1;
      end
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .Clk     (Clk),
    .Rst     (Rst),
    .i_wr_en (w_acc.wr),
    .i_waddr (r_wptr),
    .i_wdata (din),
    .i_rd_en (w_acc.rd),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN

  // Head word is valid whenever the FIFO holds data; rd_en acknowledges it.
  assign rd_valid = ~w_empty;

`else

  logic r_rd_valid;

  // rd_valid marks the cycle after an accepted read, when dout carries the word.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_acc.rd;
    end
  end

  assign rd_valid = r_rd_valid;

`endif

  assign dout         = w_rdata;
  assign count        = r_count;
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_empty = (r_count <= AE_C);
  assign almost_full  = (r_count >= AF_C);
  assign ovf          = r_ovf;
  assign udf          = r_udf;

endmodule : sync_fifo_param
